// File: rtl/seg_pkg.sv
// Shared constants, types and font table for the seven-segment text controller.
package seg_pkg;

    localparam int CHAR_W = 6;

    localparam logic [CHAR_W-1:0] CH_BLANK = 6'h3F;

    localparam logic [CHAR_W-1:0] CH_0 = 6'd0,  CH_1 = 6'd1,  CH_2 = 6'd2,  CH_3 = 6'd3;
    localparam logic [CHAR_W-1:0] CH_4 = 6'd4,  CH_5 = 6'd5,  CH_6 = 6'd6,  CH_7 = 6'd7;
    localparam logic [CHAR_W-1:0] CH_8 = 6'd8,  CH_9 = 6'd9;
    localparam logic [CHAR_W-1:0] CH_A = 6'd10, CH_B = 6'd11, CH_C = 6'd12, CH_D = 6'd13;
    localparam logic [CHAR_W-1:0] CH_E = 6'd14, CH_F = 6'd15, CH_G = 6'd16, CH_H = 6'd17;
    localparam logic [CHAR_W-1:0] CH_I = 6'd18, CH_J = 6'd19, CH_K = 6'd20, CH_L = 6'd21;
    localparam logic [CHAR_W-1:0] CH_M = 6'd22, CH_N = 6'd23, CH_O = 6'd24, CH_P = 6'd25;
    localparam logic [CHAR_W-1:0] CH_Q = 6'd26, CH_R = 6'd27, CH_S = 6'd28, CH_T = 6'd29;
    localparam logic [CHAR_W-1:0] CH_U = 6'd30, CH_V = 6'd31, CH_W = 6'd32, CH_X = 6'd33;
    localparam logic [CHAR_W-1:0] CH_Y = 6'd34, CH_Z = 6'd35;

    // Bit positions inside a segment byte (1 = lit).
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Letters that have no clean seven-segment form use the usual
    // lowercase or approximate shapes; unassigned codes render blank.
    localparam logic [7:0] FONT_TABLE [64] = '{
        0:  8'hFC, 1:  8'h60, 2:  8'hDA, 3:  8'hF2, 4:  8'h66,
        5:  8'hB6, 6:  8'hBE, 7:  8'hE0, 8:  8'hFE, 9:  8'hF6,
        10: 8'hEE, 11: 8'h3E, 12: 8'h9C, 13: 8'h7A, 14: 8'h9E,
        15: 8'h8E, 16: 8'hBC, 17: 8'h6E, 18: 8'h0C, 19: 8'h78,
        20: 8'h4E, 21: 8'h1C, 22: 8'hA8, 23: 8'h2A, 24: 8'hFC,
        25: 8'hCE, 26: 8'hE6, 27: 8'h0A, 28: 8'hB6, 29: 8'h1E,
        30: 8'h7C, 31: 8'h38, 32: 8'h54, 33: 8'h6E, 34: 8'h76,
        35: 8'hDA,
        default: 8'h00
    };

endpackage

// File: rtl/seg_font.sv
// Combinational character-code to segment-byte lookup for one digit.
module seg_font
    import seg_pkg::*;
(
    input  logic [CHAR_W-1:0] code,
    output logic [7:0]        seg
);

    // Table lookup with the decimal point forced dark.
    always_comb begin
        seg         = FONT_TABLE[code];
        seg[SEG_DP] = 1'b0;
    end

endmodule

// File: rtl/seg_text_ctrl.sv
// Text buffer, requester arbitration and registered segment encoding for the
// 8-digit seven-segment scanner.
module seg_text_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int CHAR_W      = 6,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     dec_valid,
    input  logic                     dec_del,
    input  logic [CHAR_W-1:0]        dec_char,
    output logic                     dec_ready,
    input  logic                     msg_valid,
    input  logic [DIGITS*CHAR_W-1:0] msg_data,
    output logic                     msg_ready,
    output logic [DIGITS*8-1:0]      seg_data,
    output logic [3:0]               len,
    output logic                     hold
);

    localparam int                CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CHAR_W-1:0] BLANK    = CHAR_W'(CH_BLANK);
    localparam logic [3:0]        LEN_MAX  = 4'(DIGITS);

    state_t              state;
    state_t              state_next;
    logic [CHAR_W-1:0]   disp   [DIGITS];
    logic [CHAR_W-1:0]   shadow [DIGITS];
    logic [CNT_W-1:0]    cnt;
    logic                cnt_zero;
    logic                msg_pri;
    logic                dec_fire;
    logic                msg_fire;
    logic [DIGITS*8-1:0] seg_comb;
    logic [DIGITS*8-1:0] seg_p1;

    assign cnt_zero = (cnt == '0);
    assign dec_fire = dec_valid && dec_ready;
    assign msg_fire = msg_valid && msg_ready;
    assign hold     = (state == HOLD);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: clr always returns to IDLE; a message accepted on the
    // final hold cycle wins over the restore.
    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (msg_fire) state_next = HOLD;
                HOLD: begin
                    if (msg_fire) begin
                        state_next = HOLD;
                    end else if (cnt_zero) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM outputs: ready signals from state, clr and round-robin priority.
    always_comb begin
        dec_ready = 1'b0;
        msg_ready = 1'b0;
        if (!rst && !clr) begin
            case (state)
                IDLE: begin
                    dec_ready = !(msg_valid && msg_pri);
                    msg_ready = !(dec_valid && !msg_pri);
                end
                HOLD: msg_ready = 1'b1;
                default: begin
                    dec_ready = 1'b0;
                    msg_ready = 1'b0;
                end
            endcase
        end
    end

    // Round-robin priority: the requester just granted in IDLE drops to low.
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_pri <= 1'b0;
        end else if (state == IDLE) begin
            if (dec_fire) begin
                msg_pri <= 1'b1;
            end else if (msg_fire) begin
                msg_pri <= 1'b0;
            end
        end
    end

    // Overlay countdown: loaded on every accepted message, counts in HOLD.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (msg_fire) begin
            cnt <= CNT_LOAD;
        end else if ((state == HOLD) && !cnt_zero) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Character buffer, saved decoder text and length; one operation per cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < DIGITS; i++) begin
                disp[i]   <= BLANK;
                shadow[i] <= BLANK;
            end
            len <= 4'd0;
        end else if (msg_fire) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (state == IDLE) begin
                    shadow[i] <= disp[i];
                end
                disp[i] <= msg_data[i*CHAR_W +: CHAR_W];
            end
        end else if ((state == HOLD) && cnt_zero) begin
            for (int i = 0; i < DIGITS; i++) begin
                disp[i] <= shadow[i];
            end
        end else if (dec_fire) begin
            if (!dec_del) begin
                disp[0] <= dec_char;
                for (int i = 1; i < DIGITS; i++) begin
                    disp[i] <= disp[i-1];
                end
                if (len != LEN_MAX) begin
                    len <= len + 1'b1;
                end
            end else if (len != 4'd0) begin
                for (int i = 0; i < DIGITS - 1; i++) begin
                    disp[i] <= disp[i+1];
                end
                disp[DIGITS-1] <= BLANK;
                len            <= len - 1'b1;
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_font
        seg_font u_font (
            .code (disp[g]),
            .seg  (seg_comb[g*8 +: 8])
        );
    end

    // Encode stage: segment patterns registered one cycle behind the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_p1 <= '0;
        end else begin
            seg_p1 <= seg_comb;
        end
    end

    assign seg_data = seg_p1;

endmodule

// File: tb/tb_seg_text_ctrl.sv
// Directed scoreboard bench for seg_text_ctrl with a short hold time.
module tb_seg_text_ctrl;

    localparam int K_DR   = 0;
    localparam int K_MR   = 1;
    localparam int K_LEN  = 2;
    localparam int K_HOLD = 3;
    localparam int K_SEG  = 4;

    localparam logic [47:0] MSG_E   = {8{6'd14}};
    localparam logic [47:0] MSG_A   = {8{6'd10}};
    localparam logic [47:0] MSG_DIG = {6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7};
    localparam logic [63:0] SEG_E   = {8{8'h9E}};
    localparam logic [63:0] SEG_A   = {8{8'hEE}};
    localparam logic [63:0] SEG_DIG = 64'hFC60DAF266B6BEE0;
    localparam logic [63:0] SEG_ONE = 64'h0000000000000060;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        dec_valid;
    logic        dec_del;
    logic [5:0]  dec_char;
    logic        dec_ready;
    logic        msg_valid;
    logic [47:0] msg_data;
    logic        msg_ready;
    logic [63:0] seg_data;
    logic [3:0]  len;
    logic        hold;

    typedef struct {
        string       nm;
        int          kind;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    seg_text_ctrl #(
        .DIGITS      (8),
        .CHAR_W      (6),
        .HOLD_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .dec_valid (dec_valid),
        .dec_del   (dec_del),
        .dec_char  (dec_char),
        .dec_ready (dec_ready),
        .msg_valid (msg_valid),
        .msg_data  (msg_data),
        .msg_ready (msg_ready),
        .seg_data  (seg_data),
        .len       (len),
        .hold      (hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic dv, input logic dd, input logic [5:0] dc,
                       input logic mv, input logic [47:0] md, input logic cl);
        dec_valid = dv;
        dec_del   = dd;
        dec_char  = dc;
        msg_valid = mv;
        msg_data  = md;
        clr       = cl;
    endtask

    task automatic ex(input string nm, input int kind, input logic [63:0] v);
        exp_t r;
        r.nm   = nm;
        r.kind = kind;
        r.val  = v;
        sb.push_back(r);
    endtask

    // Monitor: at every falling edge, compare all expectations queued this cycle.
    initial begin
        exp_t        r;
        logic [63:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                r = sb.pop_front();
                case (r.kind)
                    K_DR:    act = {63'd0, dec_ready};
                    K_MR:    act = {63'd0, msg_ready};
                    K_LEN:   act = {60'd0, len};
                    K_HOLD:  act = {63'd0, hold};
                    default: act = seg_data;
                endcase
                n_vec++;
                if (act !== r.val) begin
                    n_bad++;
                    $display("FAIL %s: got %h, expected %h", r.nm, act, r.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drv(0, 0, 6'd0, 0, 48'd0, 0);
        nxt();
        // Reset cycle with both requesters valid.
        drv(1, 0, 6'd1, 1, MSG_E, 0);
        ex("rst_dec_ready", K_DR, 0);
        ex("rst_msg_ready", K_MR, 0);
        ex("rst_len", K_LEN, 0);
        ex("rst_hold", K_HOLD, 0);
        ex("rst_seg", K_SEG, 0);
        nxt();
        rst = 1'b0;
        // Arbitration straight out of reset: decoder first, then message.
        ex("arb_dec_first", K_DR, 1);
        ex("arb_msg_wait", K_MR, 0);
        nxt();
        ex("arb_dec_lowpri", K_DR, 0);
        ex("arb_msg_next", K_MR, 1);
        ex("arb_len", K_LEN, 1);
        ex("arb_hold_low", K_HOLD, 0);
        nxt();  // message accepted here (N)
        drv(1, 0, 6'd1, 0, 48'd0, 0);
        ex("hold_dec_blocked", K_DR, 0);
        ex("hold_rise", K_HOLD, 1);
        ex("hold_len", K_LEN, 1);
        ex("hold_seg_old", K_SEG, SEG_ONE);
        nxt();
        ex("hold_seg_msg", K_SEG, SEG_E);
        ex("hold_dec_blocked2", K_DR, 0);
        nxt();
        ex("hold_mid", K_HOLD, 1);
        ex("hold_dec_blocked3", K_DR, 0);
        nxt();
        drv(0, 0, 6'd0, 0, 48'd0, 0);
        ex("hold_last", K_HOLD, 1);
        nxt();  // N+4: restore
        ex("restore_hold_fall", K_HOLD, 0);
        ex("restore_len", K_LEN, 1);
        ex("restore_seg_lag", K_SEG, SEG_E);
        nxt();
        ex("restore_seg", K_SEG, SEG_ONE);
        ex("restore_len2", K_LEN, 1);
        // Re-trigger: digit message, then a second message two cycles later.
        drv(0, 0, 6'd0, 1, MSG_DIG, 0);
        ex("rt_msg1_ready", K_MR, 1);
        nxt();
        drv(0, 0, 6'd0, 0, 48'd0, 0);
        ex("rt_hold", K_HOLD, 1);
        nxt();
        ex("rt_seg_order", K_SEG, SEG_DIG);
        drv(0, 0, 6'd0, 1, MSG_E, 0);
        ex("rt_msg2_ready", K_MR, 1);
        nxt();
        drv(0, 0, 6'd0, 0, 48'd0, 0);
        ex("rt_hold2", K_HOLD, 1);
        nxt();
        ex("rt_seg_msg2", K_SEG, SEG_E);
        nxt();
        ex("rt_no_early_restore", K_HOLD, 1);
        ex("rt_seg_still_msg", K_SEG, SEG_E);
        nxt();
        ex("rt_hold3", K_HOLD, 1);
        nxt();
        ex("rt_restore_hold", K_HOLD, 0);
        ex("rt_restore_len", K_LEN, 1);
        nxt();
        ex("rt_shadow_kept", K_SEG, SEG_ONE);
        // clr during a hold.
        drv(0, 0, 6'd0, 1, MSG_A, 0);
        ex("clrh_msg_ready", K_MR, 1);
        nxt();
        drv(0, 0, 6'd0, 0, 48'd0, 0);
        ex("clrh_hold", K_HOLD, 1);
        nxt();
        ex("clrh_seg_msg", K_SEG, SEG_A);
        drv(1, 0, 6'd7, 1, MSG_E, 1);
        ex("clrh_dec_ready", K_DR, 0);
        ex("clrh_msg_ready0", K_MR, 0);
        nxt();
        drv(0, 0, 6'd0, 0, 48'd0, 0);
        ex("clrh_hold_low", K_HOLD, 0);
        ex("clrh_len", K_LEN, 0);
        for (int i = 0; i < 4; i++) begin
            nxt();
            ex("clrh_stay_idle", K_HOLD, 0);
            ex("clrh_seg_blank", K_SEG, 0);
        end
        // clr with both requesters valid; priority must survive it.
        drv(1, 0, 6'd5, 0, 48'd0, 0);
        ex("clrb_append", K_DR, 1);
        nxt();
        drv(1, 0, 6'd5, 1, MSG_E, 1);
        ex("clrb_dec_ready", K_DR, 0);
        ex("clrb_msg_ready", K_MR, 0);
        ex("clrb_len_before", K_LEN, 1);
        nxt();
        drv(1, 0, 6'd5, 1, MSG_E, 0);
        ex("clrb_len", K_LEN, 0);
        ex("clrb_hold", K_HOLD, 0);
        ex("clrb_pri_dec", K_DR, 0);
        ex("clrb_pri_msg", K_MR, 1);
        nxt();
        drv(0, 0, 6'd0, 0, 48'd0, 0);
        ex("clrb_seg_blank", K_SEG, 0);
        ex("clrb_hold_on", K_HOLD, 1);
        ex("clrb_len_hold", K_LEN, 0);
        nxt();
        ex("clrb_seg_msg", K_SEG, SEG_E);
        nxt();
        nxt();
        ex("clrb_hold_last", K_HOLD, 1);
        nxt();
        ex("clrb_restore_hold", K_HOLD, 0);
        ex("clrb_restore_len", K_LEN, 0);
        nxt();
        ex("clrb_restore_blank", K_SEG, 0);
        // Delete: append A, E, then delete down past empty.
        drv(1, 0, 6'd10, 0, 48'd0, 0);
        ex("del_app_a", K_DR, 1);
        nxt();
        drv(1, 0, 6'd14, 0, 48'd0, 0);
        ex("del_app_e", K_DR, 1);
        ex("del_len1", K_LEN, 1);
        nxt();
        drv(1, 1, 6'd0, 0, 48'd0, 0);
        ex("del_first", K_DR, 1);
        ex("del_len2", K_LEN, 2);
        nxt();
        drv(0, 0, 6'd0, 0, 48'd0, 0);
        ex("del_len_after", K_LEN, 1);
        ex("del_seg_ae", K_SEG, 64'h000000000000EE9E);
        nxt();
        ex("del_seg_a", K_SEG, 64'h00000000000000EE);
        drv(1, 1, 6'd0, 0, 48'd0, 0);
        ex("del_second", K_DR, 1);
        nxt();
        ex("del_len0", K_LEN, 0);
        ex("del_empty_accepted", K_DR, 1);
        nxt();
        drv(0, 0, 6'd0, 0, 48'd0, 0);
        ex("del_len_stays0", K_LEN, 0);
        ex("del_seg_blank", K_SEG, 0);
        nxt();
        // Append 0..9 and saturate at eight characters.
        for (int i = 0; i < 10; i++) begin
            drv(1, 0, 6'(i), 0, 48'd0, 0);
            ex("app_ready", K_DR, 1);
            ex("app_len", K_LEN, (i > 8) ? 64'd8 : 64'(i));
            nxt();
        end
        drv(0, 0, 6'd0, 0, 48'd0, 0);
        ex("app_len_sat", K_LEN, 8);
        ex("app_seg_lag", K_SEG, 64'h60DAF266B6BEE0FE);
        nxt();
        ex("app_seg_final", K_SEG, 64'hDAF266B6BEE0FEF6);
        ex("app_len_final", K_LEN, 8);
        ex("app_hold_low", K_HOLD, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_text_ctrl.md
# seg_text_ctrl

Text-buffer controller and arbiter in front of the 8-digit seven-segment scanner. It shares the display between two requesters: the Morse decoder, which appends or deletes characters, and a message source, which overlays an 8-character message for a fixed time. It keeps the character buffer, arbitrates the requests, encodes characters to segment patterns, and drives the scanner's 64-bit segment input.

## Interface
Parameters:
- DIGITS, 8, number of display digits (the only supported value).
- CHAR_W, 6, width of a character code.
- HOLD_CYCLES, 50_000_000, number of cycles a message overlay stays on the display (minimum 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- clr  in  1  blanks everything; highest priority.
- dec_valid  in  1  decoder request.
- dec_del  in  1  qualifies dec_valid: 1 = delete newest char, 0 = append dec_char.
- dec_char  in  CHAR_W  character code.
- dec_ready  out  1  decoder request accepted this cycle when high with dec_valid.
- msg_valid  in  1  message request.
- msg_data  in  DIGITS*CHAR_W  message; [5:0] is the rightmost digit.
- msg_ready  out  1  message accepted when high with msg_valid.
- seg_data  out  DIGITS*8  segment patterns; [7:0] is the rightmost digit.
- len  out  4  number of valid decoder characters, 0..8.
- hold  out  1  high while a message overlay is shown.

## Operation
- Character codes: 0–9 are digits, 10–35 are A–Z, 63 (CH_BLANK) is blank, and any other code renders blank.
- Segment byte layout: bit7 = a, bit6 = b, … bit1 = g, bit0 = dp; 1 = lit; dp is always 0.
- Reference patterns: '0' = 8'hFC, '1' = 8'h60, 'A' = 8'hEE, 'E' = 8'h9E, blank = 8'h00.
- State: disp[8] is the shown buffer. shadow[8] holds the decoder text saved during a hold.
- FSM states:
  - IDLE: both requesters are eligible.
    - Append: shift disp left, put dec_char at digit 0, drop digit 7; len = min(len+1, 8).
    - Delete: shift disp right, put CH_BLANK at digit 7; len−1. With len==0 the delete is accepted as a no-op.
    - Message accept: shadow ← disp, disp ← msg_data, counter ← HOLD_CYCLES−1, go to HOLD.
  - HOLD: dec_ready = 0. msg_ready = 1.
    - A new message reloads disp and restarts the counter; shadow is not re-saved.
    - When the counter reaches 0 with no message accepted: disp ← shadow, go to IDLE.
    - len is unchanged throughout the hold.
- Arbitration, IDLE only:
  - A single valid requester is granted.
  - When both are valid, grant round-robin. After reset the decoder has priority.
  - The granted requester becomes lowest priority next time.
  - Ready signals are combinational from state, clr and the arbiter; ready never depends on the same-cycle valid of the other requester beyond arbitration.
- clr = 1:
  - disp and shadow go all-blank, len = 0, state = IDLE.
  - dec_ready and msg_ready are 0 that cycle.
  - The arbiter priority is unchanged.
- Reset values: state IDLE, disp/shadow blank, len 0, hold 0, seg_data 64'h0, decoder priority.
- dec_ready = msg_ready = 0 during the reset cycle.

## Timing
- A handshake at edge N updates disp and len at N.
- seg_data reflects the new buffer at edge N+1 (registered encoding, 1-cycle latency).
- hold rises at N with the message accept.
- A message accepted at edge N stays in disp for exactly HOLD_CYCLES cycles; shadow is restored at edge N+HOLD_CYCLES and hold falls then.
- A message accepted on the counter-zero cycle takes precedence over the restore.
- clr takes effect on the edge where it is sampled; seg_data reads 0 one cycle later.
- clr during HOLD discards the overlay.
- At most one buffer operation occurs per cycle.

## Structure
- Package seg_pkg:
  - CHAR_W.
  - CH_BLANK = 6'h3F.
  - Character-code constants for digits and letters.
  - Segment-bit constants.
  - FSM state typedef {IDLE, HOLD}.
  - The 64-entry font table.
- Sub-module seg_font: combinational code → segment-byte lookup, instantiated once per digit and registered in seg_text_ctrl.
- seg_data connects directly to the scanner's 64-bit segment input.

## Test plan
- **Append and saturate:** reset, then append codes 0..9 one per cycle → after the 10th, len=8, seg_data[7:0]=pattern('9'), seg_data[63:56]=pattern('2'), and seg_data follows disp by 1 cycle.
- **Delete:**
  - Append 'A','E', then delete → len=1, seg_data[7:0]=8'hEE.
  - Delete twice more → len=0, seg_data=0, both deletes accepted.
- **Arbitration:** with dec_valid and msg_valid held together from reset → decoder is granted first, message next cycle. While hold=1, dec_ready stays 0.
- **Hold and restore** (HOLD_CYCLES=4): text "1", message all 'E' at edge N → seg_data=all 8'h9E from N+1; restore at N+4, seg_data[7:0]=8'h60 at N+5, len=1 throughout.
- **Re-trigger:** a second message at N+2 → restore moves to N+6 and shadow is still "1".
- **clr:** clr during HOLD, and clr simultaneous with both valids → no handshake, len=0, hold=0, seg_data=0 next cycle.
